// File: rtl/qdma_sequencer.sv
// Block-transfer DMA sequencer: splits a (address, count, direction) command into
// single-word QBUS DMA cycles and streams data between the bus master and the device.
module qdma_sequencer #(
  parameter int ADDR_W = 22,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RINIT,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [15:0]       src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [15:0]       snk_data,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic              dma_read,
  output logic              dma_write,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [15:0]       dma_wdata,
  input  logic [15:0]       dma_rdata,
  input  logic              dma_complete,
  input  logic              nxm,
  input  logic              bus_master,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  residual
);

  typedef enum logic [2:0] {
    IDLE, FETCH, REQ, WAIT, RELEASE, DELIVER, FINISH
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CNT_W-1:0]  residual_reg, residual_next;
  logic [15:0]       wdata_reg, wdata_next;
  logic [15:0]       rdata_reg, rdata_next;
  logic              dir_reg, dir_next;
  logic              error_reg, error_next;

  always_ff @(posedge clk or posedge RINIT) begin
    if (RINIT) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      count_reg    <= '0;
      residual_reg <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      dir_reg      <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      residual_reg <= residual_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      dir_reg      <= dir_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    residual_next = residual_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    dir_next      = dir_reg;
    error_next    = error_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          // Word transfers only: the byte-select bit is dropped.
          addr_next  = cmd_addr & ~ADDR_W'(1);
          count_next = cmd_count;
          dir_next   = cmd_write;
          error_next = 1'b0;
          if (cmd_count == '0) begin
            residual_next = '0;
            state_next    = FINISH;
          end else begin
            state_next = cmd_write ? FETCH : REQ;
          end
        end
      end
      FETCH: begin
        if (src_valid) begin
          wdata_next = src_data;
          state_next = REQ;
        end
      end
      REQ: begin
        // Requesting while the master still holds the bus would start a spurious cycle.
        if (!bus_master) state_next = WAIT;
      end
      WAIT: begin
        if (nxm) begin
          error_next = 1'b1;
          state_next = RELEASE;
        end else if (dma_complete) begin
          if (!dir_reg) rdata_next = dma_rdata;
          count_next = count_reg - CNT_W'(1);
          addr_next  = addr_reg + ADDR_W'(2);
          state_next = dir_reg ? RELEASE : DELIVER;
        end
      end
      DELIVER: begin
        if (snk_ready) state_next = RELEASE;
      end
      RELEASE: begin
        if (!bus_master) begin
          if (error_reg || count_reg == '0) begin
            residual_next = count_reg;
            state_next    = FINISH;
          end else begin
            state_next = dir_reg ? FETCH : REQ;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requests are pure state decodes so they drop on the same edge that sees completion.
  assign cmd_ready = (state_reg == IDLE);
  assign src_ready = (state_reg == FETCH) && src_valid;
  assign snk_valid = (state_reg == DELIVER);
  assign snk_data  = rdata_reg;
  assign dma_read  = (state_reg == WAIT) && !dir_reg;
  assign dma_write = (state_reg == WAIT) && dir_reg;
  assign dma_addr  = addr_reg;
  assign dma_wdata = wdata_reg;
  assign done      = (state_reg == FINISH);
  assign error     = error_reg;
  assign residual  = residual_reg;

endmodule

// File: tb/tb_qdma_sequencer.sv
// Bench for qdma_sequencer: QBUS master, source and sink models plus a word-level
// reference of the expected bus cycles, delivered data, error flag and residual.
module tb_qdma_sequencer;

  logic        clk = 1'b0;
  logic        RINIT;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_count;
  logic [15:0] src_data, snk_data;
  logic        src_valid, src_ready, snk_valid, snk_ready;
  logic        dma_read, dma_write, dma_complete, nxm, bus_master;
  logic [21:0] dma_addr;
  logic [15:0] dma_wdata, dma_rdata;
  logic        done, error;
  logic [15:0] residual;

  qdma_sequencer #(.ADDR_W(22), .CNT_W(16)) dut (
    .clk(clk), .RINIT(RINIT),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .dma_read(dma_read), .dma_write(dma_write), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_complete(dma_complete),
    .nxm(nxm), .bus_master(bus_master),
    .done(done), .error(error), .residual(residual)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        nx;
  } xfer_t;

  xfer_t       obs_q[$];
  logic [15:0] src_q[$];
  logic [15:0] snk_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          word_no  = 0;
  int          nxm_word = -1;
  int          snk_stall = 0;
  bit          stall_master = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // QBUS master: takes the bus on a request, finishes with complete or nxm, then lets go.
  initial begin : master_model
    xfer_t t;
    bus_master = 0; dma_complete = 0; nxm = 0; dma_rdata = 0;
    forever begin
      @(negedge clk);
      if (!RINIT && (dma_read || dma_write)) begin
        t.addr = dma_addr; t.wr = dma_write; t.wdata = dma_wdata; t.rdata = 0; t.nx = 0;
        bus_master = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        while (stall_master) @(negedge clk);
        if (dma_read || dma_write) begin
          chk("req_addr_stable", dma_addr, t.addr);
          if (word_no == nxm_word) begin
            nxm = 1; t.nx = 1;
          end else begin
            t.rdata = 16'($urandom);
            dma_rdata = t.rdata;
            dma_complete = 1;
          end
          @(negedge clk);
          dma_complete = 0; nxm = 0;
          chk("req_dropped", {31'd0, dma_read | dma_write}, 0);
          obs_q.push_back(t);
          word_no++;
        end
        @(negedge clk);
        bus_master = 0;
      end
    end
  end

  initial begin : source_model
    bit pend;
    pend = 0; src_valid = 0; src_data = 0;
    forever begin
      @(negedge clk);
      if (pend && src_q.size() > 0) void'(src_q.pop_front());
      src_valid = (src_q.size() > 0);
      src_data  = src_valid ? src_q[0] : 16'd0;
      #1;
      pend = src_valid && src_ready;
    end
  end

  initial begin : sink_model
    int stall_left;
    stall_left = 0; snk_ready = 0;
    forever begin
      @(negedge clk);
      if (snk_valid) begin
        if (stall_left > 0) begin snk_ready = 0; stall_left--; end
        else snk_ready = 1;
      end else begin
        snk_ready = 0; stall_left = snk_stall;
      end
      #1;
      if (snk_valid && snk_ready) snk_q.push_back(snk_data);
    end
  end

  always @(negedge clk) begin
    if (!RINIT) chk("single_request", {31'd0, dma_read & dma_write}, 0);
  end

  task automatic run_cmd(input string name, input bit wr, input logic [21:0] a, input int cnt,
                         input int nxw, input int stall, input bit fixed);
    logic [21:0] base, ea;
    logic [15:0] wd[$];
    int          nwords, exp_res, cyc, nreads;
    bit          exp_err;
    base    = a & 22'h3FFFFE;
    exp_err = (nxw >= 0) && (nxw < cnt);
    nwords  = exp_err ? nxw + 1 : cnt;
    exp_res = exp_err ? cnt - nxw : 0;
    nreads  = wr ? 0 : (exp_err ? nxw : cnt);
    src_q.delete(); obs_q.delete(); snk_q.delete(); wd.delete();
    for (int i = 0; i < cnt; i++) begin
      if (wr) begin
        wd.push_back(fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom));
        src_q.push_back(wd[i]);
      end
    end
    word_no = 0; nxm_word = nxw; snk_stall = stall;
    @(negedge clk);
    chk({name, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_count = 16'(cnt);
    @(negedge clk);
    cmd_valid = 0;
    chk({name, "_error_cleared"}, {31'd0, error}, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk({name, "_done_seen"}, {31'd0, done}, 1);
    if (cnt == 0) chk({name, "_cnt0_latency"}, cyc, 0);
    chk({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({name, "_residual"}, residual, exp_res);
    chk({name, "_bus_released"}, {31'd0, bus_master}, 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'd0, done}, 0);
    chk({name, "_error_held"}, {31'd0, error}, {31'd0, exp_err});
    chk({name, "_bus_cycles"}, obs_q.size(), nwords);
    for (int i = 0; i < nwords && i < obs_q.size(); i++) begin
      ea = base + 22'(2 * i);
      chk({name, "_addr"}, obs_q[i].addr, ea);
      chk({name, "_dir"}, {31'd0, obs_q[i].wr}, {31'd0, wr});
      if (wr) chk({name, "_wdata"}, obs_q[i].wdata, wd[i]);
    end
    chk({name, "_snk_words"}, snk_q.size(), nreads);
    for (int i = 0; i < nreads && i < snk_q.size() && i < obs_q.size(); i++)
      chk({name, "_snk_data"}, snk_q[i], obs_q[i].rdata);
    $display("cmd %s: wr=%0d addr=%06h count=%0d cycles=%0d error=%0d residual=%0d",
             name, wr, a, cnt, obs_q.size(), error, residual);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc, dones;
    RINIT = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_count = 0;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_requests", {30'd0, dma_read, dma_write}, 0);
    chk("rst_done_error", {30'd0, done, error}, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_residual", residual, 0);
    repeat (3) @(negedge clk);
    RINIT = 0;

    run_cmd("write3", 1'b1, 22'o1000, 3, -1, 0, 1'b1);
    run_cmd("read_wrap", 1'b0, 22'h3FFFFE, 2, -1, 5, 1'b0);
    run_cmd("read_nxm", 1'b0, 22'h000400, 4, 2, 0, 1'b0);
    run_cmd("odd_addr", 1'b0, 22'o1001, 1, -1, 0, 1'b0);
    run_cmd("count0", 1'b1, 22'h001234, 0, -1, 0, 1'b0);
    run_cmd("write_nxm", 1'b1, 22'h2AAAA0, 3, 0, 0, 1'b0);

    // Reset while a read word is outstanding.
    stall_master = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 22'h000100; cmd_count = 16'd3;
    @(negedge clk);
    cmd_valid = 0;
    cyc = 0;
    while (!dma_read && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rinit_in_wait", {31'd0, dma_read}, 1);
    #2 RINIT = 1;
    #1;
    chk("rinit_requests", {30'd0, dma_read, dma_write}, 0);
    chk("rinit_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rinit_addr", dma_addr, 0);
    chk("rinit_outputs", {28'd0, done, error, snk_valid, src_ready}, 0);
    dones = 0;
    repeat (2) @(negedge clk);
    RINIT = 0; stall_master = 0;
    repeat (10) begin @(negedge clk); if (done) dones++; end
    chk("rinit_no_done", dones, 0);
    $display("cmd rinit: reset during WAIT, done pulses after=%0d", dones);

    for (int k = 0; k < 8; k++) begin
      run_cmd($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 22'($urandom),
              $urandom_range(1, 5), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : -1,
              $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
